// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 constants, types and linear transforms used by the SM4 encryptor and decryptor.
package sm4_encryptor_pkg;

  localparam int group_size_p = 128;
  localparam int key_size_p   = 128;
  localparam int word_width_p = 32;

  typedef logic [word_width_p-1:0] word_t;
  typedef logic [group_size_p-1:0] block_t;
  typedef word_t round_key_array_t [32];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } sm4_dec_state_e;

  localparam word_t FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam word_t CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic word_t rotl(input word_t w, input int n);
    return (w << n) | (w >> (word_width_p - n));
  endfunction

  // L is the data-path diffusion, L' the lighter one used by the key schedule.
  function automatic word_t l_enc(input word_t b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic word_t l_key(input word_t b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 non-linear substitution tau: four parallel S-box lookups on one 32-bit word.
module sm4_tau
  import sm4_encryptor_pkg::*;
(
  input  logic [word_width_p-1:0] a_i,
  output logic [word_width_p-1:0] b_o
);

  assign b_o = {SBOX[a_i[31:24]], SBOX[a_i[23:16]], SBOX[a_i[15:8]], SBOX[a_i[7:0]]};

endmodule

// File: rtl/sm4_decryptor.sv
// Iterative SM4 decryptor: 32-cycle key expansion, 32 reverse-order rounds, registered output.
// Optional macro SM4_DECRYPTOR_KEY_CACHE_EN skips key expansion when the key repeats.
module sm4_decryptor
  import sm4_encryptor_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [group_size_p-1:0] cipher_i,
  input  logic [key_size_p-1:0]   key_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [group_size_p-1:0] plain_o
);

  localparam int rounds_p = 32;

  sm4_dec_state_e   state_q;
  logic [4:0]       cnt_q;
  word_t            x_q [4];
  word_t            k_q [4];
  round_key_array_t rk_q;

  word_t tau_in;
  word_t tau_out;
  word_t key_next;
  word_t x_next;
  logic  last_cnt;
  logic  cache_hit;

  assign in_ready_o = (state_q == IDLE);
  assign last_cnt   = (cnt_q == 5'(rounds_p - 1));

  // One tau serves both the key schedule and the rounds.
  always_comb begin
    tau_in = x_q[1] ^ x_q[2] ^ x_q[3] ^ rk_q[5'd31 - cnt_q];
    if (state_q == KEYEXP) begin
      tau_in = k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[cnt_q];
    end
  end

  sm4_tau u_tau (
    .a_i (tau_in),
    .b_o (tau_out)
  );

  assign key_next = k_q[0] ^ l_key(tau_out);
  assign x_next   = x_q[0] ^ l_enc(tau_out);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '{default: '0};
      k_q         <= '{default: '0};
      out_valid_o <= 1'b0;
      plain_o     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            x_q     <= '{cipher_i[127:96], cipher_i[95:64], cipher_i[63:32], cipher_i[31:0]};
            k_q     <= '{key_i[127:96] ^ FK[0], key_i[95:64] ^ FK[1],
                         key_i[63:32] ^ FK[2], key_i[31:0] ^ FK[3]};
            cnt_q   <= '0;
            state_q <= cache_hit ? ROUND : KEYEXP;
          end
        end
        KEYEXP: begin
          k_q   <= '{k_q[1], k_q[2], k_q[3], key_next};
          cnt_q <= cnt_q + 5'd1;
          if (last_cnt) state_q <= ROUND;
        end
        ROUND: begin
          x_q   <= '{x_q[1], x_q[2], x_q[3], x_next};
          cnt_q <= cnt_q + 5'd1;
          if (last_cnt) state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the reversed window; then wait for the consumer.
          if (!out_valid_o) begin
            plain_o     <= {x_q[3], x_q[2], x_q[1], x_q[0]};
            out_valid_o <= 1'b1;
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == KEYEXP) rk_q[cnt_q] <= key_next;
  end

`ifdef SM4_DECRYPTOR_KEY_CACHE_EN
  block_t last_key_q;
  logic   key_cached_q;

  assign cache_hit = key_cached_q && (key_i == last_key_q);

  // The flag is only raised once the whole schedule for last_key_q is in the file.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      key_cached_q <= 1'b0;
      last_key_q   <= '0;
    end else if (state_q == IDLE && in_valid_i && !cache_hit) begin
      key_cached_q <= 1'b0;
      last_key_q   <= key_i;
    end else if (state_q == KEYEXP && last_cnt) begin
      key_cached_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sm4_decryptor.sv
// Self-checking bench for sm4_decryptor: known-answer vector, round trips, backpressure,
// mid-operation reset, input hold and key-cache latency.
module tb_sm4_decryptor;
  import sm4_encryptor_pkg::*;

`ifdef SM4_DECRYPTOR_KEY_CACHE_EN
  localparam bit cache_en = 1'b1;
`else
  localparam bit cache_en = 1'b0;
`endif

  typedef struct {
    logic [127:0] key;
    logic [127:0] cipher;
    logic [127:0] plain;
  } vec_t;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] cipher_i;
  logic [127:0] key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] plain_o;

  int compared   = 0;
  int mismatched = 0;

  logic         model_cached   = 1'b0;
  logic [127:0] model_last_key = '0;

  vec_t vecs [8];

  sm4_decryptor dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .cipher_i    (cipher_i),
    .key_i       (key_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .plain_o     (plain_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rot(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] sub_bytes(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Forward SM4 encryption, used to produce ciphertexts for round-trip vectors.
  function automatic logic [127:0] sm4_encrypt(input logic [127:0] key, input logic [127:0] plain);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127 - 32*i -: 32] ^ FK[i];
      x[i] = plain[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      t = sub_bytes(k[i+1] ^ k[i+2] ^ k[i+3] ^ CK[i]);
      k[i+4] = k[i] ^ t ^ rot(t, 13) ^ rot(t, 23);
    end
    for (int i = 0; i < 32; i++) begin
      t = sub_bytes(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ t ^ rot(t, 2) ^ rot(t, 10) ^ rot(t, 18) ^ rot(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one request and returns the edges from accept to out_valid.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] cipher,
                               input bit scramble, output int lat);
    int w = 0;
    while (!in_ready_o && w < 300) begin
      @(posedge clk_i); #1; w++;
    end
    cipher_i   = cipher;
    key_i      = key;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 200) begin
      if (scramble) begin
        cipher_i = rand128();
        key_i    = rand128();
      end
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic run_vector(input vec_t v, input bit scramble, input string name);
    int lat;
    int exp_lat;
    exp_lat = (cache_en && model_cached && v.key == model_last_key) ? 33 : 65;
    applyStimulus(v.key, v.cipher, scramble, lat);
    checkOutput({name, " latency"}, 128'(lat), 128'(exp_lat));
    checkOutput({name, " plain"}, plain_o, v.plain);
    if (exp_lat == 65) begin
      model_cached   = 1'b1;
      model_last_key = v.key;
    end
  endtask

  initial begin
    int lat;
    logic [127:0] held;
    vec_t extra;

    vecs[0] = '{key:    128'h0123456789abcdeffedcba9876543210,
                cipher: 128'h681edf34d206965e86b3e94f536e4246,
                plain:  128'h0123456789abcdeffedcba9876543210};
    for (int i = 1; i < 8; i++) begin
      vecs[i].key    = rand128();
      vecs[i].plain  = rand128();
      vecs[i].cipher = sm4_encrypt(vecs[i].key, vecs[i].plain);
    end

    reset_n_i   = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    cipher_i    = '0;
    key_i       = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset in_ready", 128'(in_ready_o), 128'd1);
    checkOutput("reset out_valid", 128'(out_valid_o), 128'd0);
    checkOutput("reset plain", plain_o, 128'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) begin
      run_vector(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    $display("[TB] backpressure");
    while (!in_ready_o) begin
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b0;
    run_vector(vecs[0], 1'b0, "bp");
    held = plain_o;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      checkOutput("bp plain stable", plain_o, held);
      checkOutput("bp in_ready low", 128'(in_ready_o), 128'd0);
      checkOutput("bp out_valid held", 128'(out_valid_o), 128'd1);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("bp idle in_ready", 128'(in_ready_o), 128'd1);
    checkOutput("bp idle out_valid", 128'(out_valid_o), 128'd0);

    $display("[TB] reset mid-operation");
    cipher_i   = vecs[1].cipher;
    key_i      = vecs[1].key;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    #1;
    checkOutput("midreset out_valid", 128'(out_valid_o), 128'd0);
    checkOutput("midreset in_ready", 128'(in_ready_o), 128'd1);
    checkOutput("midreset plain", plain_o, 128'd0);
    model_cached = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    run_vector(vecs[0], 1'b0, "after reset");

    $display("[TB] input hold");
    run_vector(vecs[0], 1'b1, "hold");

    $display("[TB] key reuse");
    extra.key    = vecs[2].key;
    extra.plain  = rand128();
    extra.cipher = sm4_encrypt(extra.key, extra.plain);
    run_vector(vecs[2], 1'b0, "reuse first");
    run_vector(extra, 1'b0, "reuse second");
    run_vector(vecs[3], 1'b0, "reuse newkey");

    applyStimulus(vecs[4].key, vecs[4].cipher, 1'b0, lat);
    checkOutput("final plain", plain_o, vecs[4].plain);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
